// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable synchronised lock,
// then releases the downstream reset and retries on lock timeout or lock loss.
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_SETTLE_CYCLES  = 1024,
  parameter int unsigned LOSS_FILTER         = 4,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_SETTLE_CYCLES) ?
                                      CNT_MAX_A : LOCK_SETTLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned LOSS_W    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam int unsigned RETRY_W   = 8;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = {RETRY_W{1'b1}};

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_q, sys_rst_d;
  logic                 ready_q, ready_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 lk;
  logic [RETRY_W-1:0]   retry_inc;

  // Synchroniser for the asynchronous lock flag; lk is the only lock view used below.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk        = sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

  // Next-state logic; the shared counter restarts from 0 on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    loss_d      = '0;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
          retry_d = retry_inc;
        end
      end
      ST_SETTLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lk) begin
          if (loss_q == LOSS_LAST) begin
            state_d     = ST_PLL_RESET;
            lock_lost_d = 1'b1;
            retry_d     = retry_inc;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == ST_PLL_RESET);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: main instance (TIMEOUT=1024, SETTLE=64) plus a
// short-timeout instance for retry_count saturation.
module tb_pll_reset_ctrl;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  logic       rst2_n;
  logic       pll_locked2;
  logic       pll_rst2;
  logic       sys_rst2;
  logic       ready2;
  logic       lock_lost2;
  logic [7:0] retry_count2;

  int passed;
  int total;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (16),
    .LOCK_TIMEOUT_CYCLES(1024),
    .LOCK_SETTLE_CYCLES (64),
    .LOSS_FILTER        (4),
    .SYNC_STAGES        (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (16),
    .LOCK_TIMEOUT_CYCLES(8),
    .LOCK_SETTLE_CYCLES (64),
    .LOSS_FILTER        (4),
    .SYNC_STAGES        (2)
  ) dut_sat (
    .refclk     (refclk),
    .rst_n      (rst2_n),
    .pll_locked (pll_locked2),
    .pll_rst    (pll_rst2),
    .sys_rst    (sys_rst2),
    .ready      (ready2),
    .lock_lost  (lock_lost2),
    .retry_count(retry_count2)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic test_reset();
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    rst2_n      = 1'b0;
    pll_locked2 = 1'b0;
    repeat (3) @(negedge refclk);
    total++;
    if ({pll_rst, sys_rst, ready, lock_lost} !== 4'b1100) begin
      $display("FAIL reset_outputs: got pll_rst,sys_rst,ready,lock_lost=%b want 1100",
               {pll_rst, sys_rst, ready, lock_lost});
    end else passed++;
    total++;
    if (retry_count !== 8'd0) begin
      $display("FAIL reset_retry: got %0d want 0", retry_count);
    end else passed++;
  endtask

  task automatic test_first_lock();
    int hi;
    int m;
    rst_n = 1'b1;
    hi = 0;
    while (pll_rst === 1'b1 && hi < 100) begin
      hi++;
      @(negedge refclk);
    end
    total++;
    if (hi != 16) begin
      $display("FAIL first_pll_rst_width: got %0d want 16", hi);
    end else passed++;
    repeat (100) @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    m = 0;
    while (m < 300) begin
      @(negedge refclk);
      m++;
      if (sys_rst !== 1'b1) break;
    end
    total++;
    if (m != 66) begin
      $display("FAIL first_release_latency: got %0d edges want 66", m);
    end else passed++;
    total++;
    if ({sys_rst, ready, pll_rst} !== 3'b010) begin
      $display("FAIL first_release_outputs: got sys_rst,ready,pll_rst=%b want 010",
               {sys_rst, ready, pll_rst});
    end else passed++;
    total++;
    if (retry_count !== 8'd0) begin
      $display("FAIL first_retry: got %0d want 0", retry_count);
    end else passed++;
  endtask

  task automatic test_run_glitch();
    int bad;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge refclk);
      if (lock_lost !== 1'b0 || sys_rst !== 1'b0 || ready !== 1'b1 || pll_rst !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) begin
      $display("FAIL run_glitch_3: got %0d disturbed cycles want 0", bad);
    end else passed++;
  endtask

  task automatic test_lock_loss();
    int pulses;
    int hi;
    int bad_edge;
    int w;
    pll_locked = 1'b0;
    repeat (4) @(negedge refclk);
    pll_locked = 1'b1;
    pulses   = 0;
    hi       = 0;
    bad_edge = 0;
    repeat (40) begin
      @(negedge refclk);
      if (lock_lost === 1'b1) begin
        pulses++;
        if ({sys_rst, ready, pll_rst} !== 3'b101) bad_edge++;
      end
      if (pll_rst === 1'b1) hi++;
    end
    total++;
    if (pulses != 1) begin
      $display("FAIL loss_pulse_count: got %0d want 1", pulses);
    end else passed++;
    total++;
    if (bad_edge != 0) begin
      $display("FAIL loss_edge_outputs: got %0d bad samples want 0", bad_edge);
    end else passed++;
    total++;
    if (hi != 16) begin
      $display("FAIL loss_pll_rst_width: got %0d want 16", hi);
    end else passed++;
    total++;
    if (retry_count !== 8'd1) begin
      $display("FAIL loss_retry: got %0d want 1", retry_count);
    end else passed++;
    w = 0;
    while (ready !== 1'b1 && w < 300) begin
      @(negedge refclk);
      w++;
    end
    total++;
    if (ready !== 1'b1) begin
      $display("FAIL loss_relock: ready got %b want 1 after %0d cycles", ready, w);
    end else passed++;
  endtask

  task automatic test_async_reset();
    total++;
    if (ready !== 1'b1) begin
      $display("FAIL async_pre_run: ready got %b want 1", ready);
    end else passed++;
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pll_rst, sys_rst, ready, lock_lost} !== 4'b1100 || retry_count !== 8'd0) begin
      $display("FAIL async_reset: got outputs=%b retry=%0d want 1100 retry=0",
               {pll_rst, sys_rst, ready, lock_lost}, retry_count);
    end else passed++;
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
  endtask

  task automatic test_settle_glitch();
    int w;
    int m;
    rst_n = 1'b1;
    w = 0;
    while (pll_rst === 1'b1 && w < 100) begin
      @(negedge refclk);
      w++;
    end
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    m = 0;
    while (m < 400) begin
      @(negedge refclk);
      m++;
      if (m == 31) pll_locked = 1'b0;
      if (m == 32) pll_locked = 1'b1;
      if (sys_rst !== 1'b1) break;
    end
    total++;
    if (m != 99) begin
      $display("FAIL settle_glitch_release: got %0d edges want 99", m);
    end else passed++;
    total++;
    if (ready !== 1'b1 || retry_count !== 8'd0) begin
      $display("FAIL settle_glitch_state: ready=%b retry=%0d want 1 and 0", ready, retry_count);
    end else passed++;
  endtask

  task automatic test_timeouts();
    int idx;
    int rises;
    int last_rise;
    int hi;
    int bad_width;
    int bad_period;
    int bad_retry;
    int sys_low;
    logic prev;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n      = 1'b1;
    prev       = pll_rst;
    hi         = (pll_rst === 1'b1) ? 1 : 0;
    rises      = 0;
    last_rise  = 0;
    bad_width  = 0;
    bad_period = 0;
    bad_retry  = 0;
    sys_low    = 0;
    for (idx = 1; idx <= 3200; idx++) begin
      @(negedge refclk);
      if (sys_rst !== 1'b1) sys_low++;
      if (pll_rst === 1'b1) begin
        if (prev !== 1'b1) begin
          rises++;
          if (retry_count !== 8'(rises)) bad_retry++;
          if (rises > 1 && idx - last_rise != 1040) bad_period++;
          last_rise = idx;
          hi = 0;
        end
        hi++;
      end else if (prev === 1'b1 && hi != 16) begin
        bad_width++;
      end
      prev = pll_rst;
    end
    total++;
    if (rises != 3) begin
      $display("FAIL timeout_rises: got %0d want 3", rises);
    end else passed++;
    total++;
    if (bad_retry != 0) begin
      $display("FAIL timeout_retry_seq: got %0d wrong values want 0", bad_retry);
    end else passed++;
    total++;
    if (bad_period != 0) begin
      $display("FAIL timeout_period: got %0d wrong periods want 0", bad_period);
    end else passed++;
    total++;
    if (bad_width != 0) begin
      $display("FAIL timeout_pulse_width: got %0d wrong widths want 0", bad_width);
    end else passed++;
    total++;
    if (sys_low != 0) begin
      $display("FAIL timeout_sys_rst: got %0d low samples want 0", sys_low);
    end else passed++;
  endtask

  task automatic test_saturation();
    int n;
    int wraps;
    logic [7:0] prev;
    rst2_n = 1'b1;
    n      = 0;
    wraps  = 0;
    prev   = retry_count2;
    while (n < 7300) begin
      @(negedge refclk);
      n++;
      if (retry_count2 < prev) wraps++;
      prev = retry_count2;
      if (n == 240) begin
        total++;
        if (retry_count2 !== 8'd10) begin
          $display("FAIL sat_retry_10: got %0d want 10", retry_count2);
        end else passed++;
      end
      if (n == 6119) begin
        total++;
        if (retry_count2 !== 8'd254) begin
          $display("FAIL sat_retry_254: got %0d want 254", retry_count2);
        end else passed++;
      end
      if (n == 6120) begin
        total++;
        if (retry_count2 !== 8'd255) begin
          $display("FAIL sat_retry_255: got %0d want 255", retry_count2);
        end else passed++;
      end
    end
    total++;
    if (retry_count2 !== 8'd255 || wraps != 0) begin
      $display("FAIL sat_hold: got %0d wraps=%0d want 255 wraps=0", retry_count2, wraps);
    end else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_first_lock();
    test_run_glitch();
    test_lock_loss();
    test_async_reset();
    test_settle_glitch();
    test_timeouts();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
